// File: rtl/mem_loader_pkg.sv
// ---------------------------------------------------------------------------
// mem_loader_pkg
//  Shared definitions for the boot-time program loader:
//   - state_t         : loader FSM states
//   - I_START_ADDRESS : default first write address (start of instruction space)
//   - LEN_W           : width of the frame length field (2 bytes, LSB first)
//   - BYTE_W / WORD_W : stream byte and RAM word widths
//   - is_armable()    : states in which a start pulse is honoured
// ---------------------------------------------------------------------------
package mem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        CSUM  = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

    localparam logic [31:0] I_START_ADDRESS = 32'h0040_0000;
    localparam int          LEN_W           = 16;
    localparam int          BYTE_W          = 8;
    localparam int          WORD_W          = 32;

    // A start pulse only re-arms the loader when no frame is in flight.
    function automatic logic is_armable(input state_t s);
        return (s == IDLE) || (s == DONE) || (s == ERR);
    endfunction

endpackage

// File: rtl/mem_loader_word_packer.sv
// ---------------------------------------------------------------------------
// mem_loader_word_packer
//  Packs a byte stream little-endian into 32-bit words. The first byte of a
//  word ends up in bits [7:0]. word_valid is a combinational pulse in the
//  same cycle the fourth byte is presented, so the caller can capture the
//  full word on the very edge that consumes that byte.
// Ports:
//  clk_100M    in   clock
//  reset       in   async, active-high
//  clear       in   restart packing at byte 0 (new frame)
//  byte_valid  in   byte_data is consumed this cycle
//  byte_data   in   8-bit stream byte
//  word_valid  out  fourth byte of a word is being consumed this cycle
//  word_data   out  assembled word (valid while word_valid=1)
// ---------------------------------------------------------------------------
module mem_loader_word_packer
    import mem_loader_pkg::*;
(
    input  logic              clk_100M,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data
);

    // Holds the three earlier bytes of the word; each new byte enters at the
    // top so that after three bytes the first one has reached bits [7:0].
    logic [WORD_W-BYTE_W-1:0] shreg;
    logic [1:0]               byte_cnt;

    assign word_valid = byte_valid && (byte_cnt == 2'd3);
    assign word_data  = {byte_data, shreg};

    always_ff @(posedge clk_100M or posedge reset) begin
        if (reset) begin
            shreg    <= '0;
            byte_cnt <= 2'd0;
        end else if (clear) begin
            shreg    <= '0;
            byte_cnt <= 2'd0;
        end else if (byte_valid) begin
            shreg    <= {byte_data, shreg[WORD_W-BYTE_W-1:BYTE_W]};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/mem_loader.sv
// ---------------------------------------------------------------------------
// mem_loader
//  Boot-time program loader in front of the unified instruction/data RAM.
//  Receives a frame over a valid/ready byte stream:
//     length N (2 bytes, LSB first), then 4*N data bytes (LSB first per word)
//  and writes the words to consecutive RAM addresses starting at BASE_ADDR,
//  holding wr_en for WR_HOLD cycles per word so the slow RAM clock sees it.
//  The processor is held in reset (cpu_hold) while a frame is being loaded
//  and after a failed load.
//
//  Optional feature: define MEM_LOADER_CHECKSUM_EN to append one checksum
//  byte to every frame; it must equal the XOR of all data bytes (8'h00 for
//  an empty frame), otherwise the load ends in the error state.
//
// Parameters:
//  BASE_ADDR   first write address (word aligned)
//  MAX_WORDS   largest length field accepted; larger lengths are an error
//  WR_HOLD     cycles wr_en stays high for each word
//  TIMEOUT     idle cycles tolerated between bytes inside a frame
// Ports:
//  clk_100M      in   clock
//  reset         in   async, active-high
//  start         in   1-cycle arm pulse (honoured in IDLE/DONE/ERR only)
//  rx_data       in   stream byte
//  rx_valid      in   rx_data valid
//  rx_ready      out  byte accepted this cycle when rx_valid is also high
//  wr_en         out  RAM write enable
//  addr          out  RAM byte address
//  w_data        out  RAM write data
//  cpu_hold      out  keep processor in reset
//  busy          out  frame in progress
//  done          out  last frame loaded successfully (sticky until start)
//  error         out  last frame failed (sticky until start)
//  words_loaded  out  words written in the current/last frame
// ---------------------------------------------------------------------------
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = I_START_ADDRESS,
    parameter int          MAX_WORDS = 512,
    parameter int          WR_HOLD   = 4,
    parameter int          TIMEOUT   = 1_000_000
) (
    input  logic              clk_100M,
    input  logic              reset,
    input  logic              start,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [31:0]       addr,
    output logic [WORD_W-1:0] w_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [LEN_W-1:0]  words_loaded
);

    localparam int          HOLD_W      = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;
    localparam int          IDLE_W      = $clog2(TIMEOUT + 1);
    localparam logic [31:0] MAX_WORDS_U = 32'(MAX_WORDS);

`ifdef MEM_LOADER_CHECKSUM_EN
    // After the last word (or an empty length) the checksum byte follows.
    localparam state_t FINAL_ST = CSUM;
`else
    localparam state_t FINAL_ST = DONE;
`endif

    state_t              state;
    state_t              state_nx;

    logic                xfer;
    logic                arm;
    logic                timeout_hit;
    logic                hold_last;
    logic                last_word;
    logic                len_phase;
    logic                len_zero;
    logic                len_over;
    logic [BYTE_W-1:0]   len_lo;
    logic [LEN_W-1:0]    len_n;
    logic [LEN_W-1:0]    len_field;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [IDLE_W-1:0]   idle_cnt;
    logic                word_valid;
    logic [WORD_W-1:0]   word_data;

`ifdef MEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]   csum;
    logic                csum_ok;
    assign csum_ok = (rx_data == csum);
`endif

    // -----------------------------------------------------------------------
    // Status decode (all derived from the registered state)
    // -----------------------------------------------------------------------
    assign rx_ready = (state == LEN) || (state == DATA) || (state == CSUM);
    assign wr_en    = (state == WRITE);
    assign busy     = (state == LEN) || (state == DATA) ||
                      (state == WRITE) || (state == CSUM);
    // Processor stays in reset after a failed load so it never runs a
    // partially written image.
    assign cpu_hold = busy || (state == ERR);
    assign done     = (state == DONE);
    assign error    = (state == ERR);

    assign xfer      = rx_valid && rx_ready;
    assign arm       = start && is_armable(state);
    assign len_field = {rx_data, len_lo};
    assign len_zero  = (len_field == '0);
    assign len_over  = ({16'd0, len_field} > MAX_WORDS_U);
    assign last_word = ((words_loaded + 16'd1) == len_n);
    assign hold_last = (hold_cnt == HOLD_W'(WR_HOLD - 1));
    // A byte arriving in the cycle the limit is reached still wins.
    assign timeout_hit = rx_ready && !xfer && (idle_cnt == IDLE_W'(TIMEOUT - 1));

    mem_loader_word_packer u_word_packer (
        .clk_100M   (clk_100M),
        .reset      (reset),
        .clear      (arm),
        .byte_valid (xfer && (state == DATA)),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_100M or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_nx = LEN;
                end
            end
            LEN: begin
                if (timeout_hit) begin
                    state_nx = ERR;
                end else if (xfer && len_phase) begin
                    if (len_zero) begin
                        state_nx = FINAL_ST;
                    end else if (len_over) begin
                        state_nx = ERR;
                    end else begin
                        state_nx = DATA;
                    end
                end
            end
            DATA: begin
                if (timeout_hit) begin
                    state_nx = ERR;
                end else if (word_valid) begin
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                if (hold_last) begin
                    state_nx = last_word ? FINAL_ST : DATA;
                end
            end
            CSUM: begin
`ifdef MEM_LOADER_CHECKSUM_EN
                if (timeout_hit) begin
                    state_nx = ERR;
                end else if (xfer) begin
                    state_nx = csum_ok ? DONE : ERR;
                end
`else
                // Unreachable without the checksum feature.
                state_nx = ERR;
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: length capture, word latch, write hold, address/count update
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_100M or posedge reset) begin
        if (reset) begin
            addr         <= BASE_ADDR;
            w_data       <= '0;
            words_loaded <= '0;
            len_n        <= '0;
            len_lo       <= '0;
            len_phase    <= 1'b0;
            hold_cnt     <= '0;
            idle_cnt     <= '0;
        end else begin
            // Counts only idle cycles while a byte is expected.
            if (!rx_ready || xfer) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (arm) begin
                addr         <= BASE_ADDR;
                words_loaded <= '0;
                len_phase    <= 1'b0;
            end

            if ((state == LEN) && xfer) begin
                if (!len_phase) begin
                    len_lo    <= rx_data;
                    len_phase <= 1'b1;
                end else begin
                    len_n     <= len_field;
                    len_phase <= 1'b0;
                end
            end

            // w_data is captured on entry to WRITE and left untouched until
            // the next word, so it is stable across the whole wr_en window.
            if ((state == DATA) && word_valid) begin
                w_data   <= word_data;
                hold_cnt <= '0;
            end

            // addr advances on the edge that ends the wr_en window.
            if (state == WRITE) begin
                hold_cnt <= hold_cnt + 1'b1;
                if (hold_last) begin
                    addr         <= addr + 32'd4;
                    words_loaded <= words_loaded + 16'd1;
                end
            end
        end
    end

`ifdef MEM_LOADER_CHECKSUM_EN
    // Running XOR over the data bytes of the current frame.
    always_ff @(posedge clk_100M or posedge reset) begin
        if (reset) begin
            csum <= '0;
        end else if (arm) begin
            csum <= '0;
        end else if ((state == DATA) && xfer) begin
            csum <= csum ^ rx_data;
        end
    end
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Testbench for mem_loader. Runs with a shortened TIMEOUT so the idle-timeout
// case fits in a short simulation. Writes seen on the RAM port are checked by
// a monitor against expected (addr, data) pairs produced by a frame model.
module tb_mem_loader;

    localparam logic [31:0] BASE = 32'h0040_0000;
    localparam int          HOLD = 4;
    localparam int          TO   = 300;
    localparam int          MAXW = 512;

    logic        clk_100M = 1'b0;
    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic [7:0]  rx_data  = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] w_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int checks   = 0;
    int failures = 0;
    int wr_count = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [7:0]  acc_q[$];
    logic [7:0]  frame_q[$];

    // Monitor state
    logic        m_in_wr = 1'b0;
    logic        m_stab  = 1'b1;
    logic [31:0] m_a, m_d, m_ea, m_ed;
    int          m_n = 0;

    always #5 clk_100M = ~clk_100M;

    mem_loader #(
        .BASE_ADDR (BASE),
        .MAX_WORDS (MAXW),
        .WR_HOLD   (HOLD),
        .TIMEOUT   (TO)
    ) dut (
        .clk_100M     (clk_100M),
        .reset        (reset),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .wr_en        (wr_en),
        .addr         (addr),
        .w_data       (w_data),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    // RAM-port / stream monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk_100M);
            if (reset) begin
                m_in_wr = 1'b0;
            end else begin
                if (rx_valid && rx_ready) acc_q.push_back(rx_data);
                if (wr_en) begin
                    checks++;
                    if (rx_ready !== 1'b0) begin
                        failures++;
                        $display("FAIL ready_in_write: rx_ready=%b required 0 at %0t", rx_ready, $time);
                    end
                    if (!m_in_wr) begin
                        m_in_wr = 1'b1; m_a = addr; m_d = w_data; m_n = 1; m_stab = 1'b1;
                    end else begin
                        m_n++;
                        if ((addr !== m_a) || (w_data !== m_d)) m_stab = 1'b0;
                    end
                end else if (m_in_wr) begin
                    m_in_wr = 1'b0;
                    wr_count++;
                    checks++;
                    if (exp_addr_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_write: addr=%h data=%h required no write", m_a, m_d);
                    end else begin
                        m_ea = exp_addr_q.pop_front();
                        m_ed = exp_data_q.pop_front();
                        if ({m_a, m_d} !== {m_ea, m_ed}) begin
                            failures++;
                            $display("FAIL write_word: got %h@%h required %h@%h", m_d, m_a, m_ed, m_ea);
                        end
                        checks++;
                        if (m_n !== HOLD) begin
                            failures++;
                            $display("FAIL wr_en_width: got %0d cycles required %0d", m_n, HOLD);
                        end
                        checks++;
                        if (m_stab !== 1'b1) begin
                            failures++;
                            $display("FAIL write_stable: addr/w_data moved inside wr_en window (got %b required 1)", m_stab);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_100M);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) tick();
        exp_addr_q.delete(); exp_data_q.delete(); acc_q.delete();
        reset = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        guard = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk_100M);
        while ((rx_ready !== 1'b1) && (guard < 200)) begin
            guard++;
            @(negedge clk_100M);
        end
        if (rx_ready !== 1'b1) begin
            checks++; failures++;
            $display("FAIL byte_accept_timeout: rx_ready=%b required 1", rx_ready);
        end
        @(posedge clk_100M);
        #1;
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic send_frame(input int gapmax, input bit mid_start);
        for (int i = 0; i < frame_q.size(); i++) begin
            if (mid_start && (i == 3)) begin
                rx_valid = 1'b0;
                pulse_start();
            end
            send_byte(frame_q[i], (gapmax == 0) ? 0 : int'($urandom_range(0, gapmax)));
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_end();
        bit ok;
        ok = 1'b0;
        for (int i = 0; (i < 60) && !ok; i++) begin
            @(negedge clk_100M);
            if (done || error) ok = 1'b1;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL frame_end_timeout: done=%b error=%b required one set", done, error);
        end
        tick();
    endtask

    // Frame model: random words, each split into 4 bytes LSB first; the
    // expected RAM image is word w at BASE + 4*w. x returns the XOR of the
    // data bytes (the checksum byte, when that feature is present).
    task automatic make_frame(input int n, output logic [7:0] x);
        logic [31:0] word;
        frame_q.delete();
        x = 8'h00;
        frame_q.push_back(n[7:0]);
        frame_q.push_back(n[15:8]);
        for (int w = 0; w < n; w++) begin
            word = $urandom();
            for (int b = 0; b < 4; b++) begin
                frame_q.push_back(word[8*b +: 8]);
                x = x ^ word[8*b +: 8];
            end
            exp_addr_q.push_back(BASE + 32'(w * 4));
            exp_data_q.push_back(word);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        checks++;
        if ({rx_ready, wr_en, cpu_hold, busy, done, error} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b required 000000", {rx_ready, wr_en, cpu_hold, busy, done, error});
        end
        checks++;
        if ({addr, w_data, words_loaded} !== {BASE, 32'h0, 16'h0}) begin
            failures++;
            $display("FAIL reset_regs: addr=%h w_data=%h words=%0d required %h 0 0", addr, w_data, words_loaded, BASE);
        end
        do_reset();
        // Bytes offered while idle must not be taken.
        rx_data = 8'hA5; rx_valid = 1'b1;
        repeat (5) tick();
        rx_valid = 1'b0;
        checks++;
        if (acc_q.size() !== 0 || rx_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_accept: accepted=%0d rx_ready=%b required 0 0", acc_q.size(), rx_ready);
        end
    endtask

    task automatic test_basic();
        logic [7:0] x;
        int wc0;
        wc0 = wr_count;
        pulse_start();
        checks++;
        if ({busy, cpu_hold, rx_ready} !== 3'b111) begin
            failures++;
            $display("FAIL armed_flags: got %b required 111", {busy, cpu_hold, rx_ready});
        end
        frame_q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        exp_addr_q.push_back(32'h0040_0000); exp_data_q.push_back(32'h1234_5678);
        exp_addr_q.push_back(32'h0040_0004); exp_data_q.push_back(32'hDEAD_BEEF);
        x = 8'h00;
        for (int i = 2; i < frame_q.size(); i++) x = x ^ frame_q[i];
`ifdef MEM_LOADER_CHECKSUM_EN
        frame_q.push_back(x);
`endif
        send_frame(2, 1'b0);
        wait_end();
        checks++;
        if ({done, error, cpu_hold, busy} !== 4'b1000) begin
            failures++;
            $display("FAIL basic_status: done,error,hold,busy=%b required 1000", {done, error, cpu_hold, busy});
        end
        checks++;
        if (words_loaded !== 16'd2) begin
            failures++;
            $display("FAIL basic_words: got %0d required 2", words_loaded);
        end
        checks++;
        if (addr !== BASE + 32'd8) begin
            failures++;
            $display("FAIL basic_addr_end: got %h required %h", addr, BASE + 32'd8);
        end
        checks++;
        if ((wr_count - wc0) !== 2 || exp_addr_q.size() !== 0) begin
            failures++;
            $display("FAIL basic_write_count: got %0d pending %0d required 2 0", wr_count - wc0, exp_addr_q.size());
        end
    endtask

    task automatic test_zero_len();
        int wc0;
        wc0 = wr_count;
        pulse_start();
        checks++;
        if ({done, words_loaded, addr} !== {1'b0, 16'h0, BASE}) begin
            failures++;
            $display("FAIL rearm_clear: done=%b words=%0d addr=%h required 0 0 %h", done, words_loaded, addr, BASE);
        end
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef MEM_LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        rx_valid = 1'b0;
        checks++;
        if ({done, cpu_hold, busy} !== 3'b100) begin
            failures++;
            $display("FAIL zero_len_done: done,hold,busy=%b required 100", {done, cpu_hold, busy});
        end
        repeat (8) tick();
        checks++;
        if ((wr_count - wc0) !== 0 || words_loaded !== 16'd0) begin
            failures++;
            $display("FAIL zero_len_writes: writes=%0d words=%0d required 0 0", wr_count - wc0, words_loaded);
        end
    endtask

    task automatic test_too_long();
        int wc0;
        int acc0;
        wc0 = wr_count;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        rx_valid = 1'b0;
        checks++;
        if ({error, cpu_hold, busy, rx_ready} !== 4'b1100) begin
            failures++;
            $display("FAIL too_long_err: error,hold,busy,ready=%b required 1100", {error, cpu_hold, busy, rx_ready});
        end
        acc0 = acc_q.size();
        rx_data = 8'h33; rx_valid = 1'b1;
        repeat (10) tick();
        rx_valid = 1'b0;
        checks++;
        if ((wr_count - wc0) !== 0 || acc_q.size() !== acc0 || error !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky: writes=%0d accepted=%0d error=%b required 0 0 1", wr_count - wc0, acc_q.size() - acc0, error);
        end
        pulse_start();
        checks++;
        if ({error, busy, words_loaded, addr} !== {1'b0, 1'b1, 16'h0, BASE}) begin
            failures++;
            $display("FAIL err_rearm: error=%b busy=%b words=%0d addr=%h required 0 1 0 %h", error, busy, words_loaded, addr, BASE);
        end
        // Exactly MAX_WORDS is still accepted.
        send_byte(MAXW[7:0], 0);
        send_byte(MAXW[15:8], 0);
        rx_valid = 1'b0;
        checks++;
        if ({error, busy, rx_ready} !== 3'b011) begin
            failures++;
            $display("FAIL max_len_ok: error,busy,ready=%b required 011", {error, busy, rx_ready});
        end
        do_reset();
    endtask

    task automatic test_timeout();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        rx_valid = 1'b0;
        repeat (TO) @(negedge clk_100M);
        checks++;
        if ({error, busy} !== 2'b01) begin
            failures++;
            $display("FAIL timeout_early: error,busy=%b required 01", {error, busy});
        end
        @(negedge clk_100M);
        checks++;
        if ({error, busy, cpu_hold} !== 3'b101) begin
            failures++;
            $display("FAIL timeout_err: error,busy,hold=%b required 101", {error, busy, cpu_hold});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse_start();
        frame_q = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03};
        send_frame(0, 1'b0);
        reset = 1'b1;
        #1;
        checks++;
        if ({rx_ready, wr_en, cpu_hold, busy, done, error, addr, w_data, words_loaded} !==
            {6'b0, BASE, 32'h0, 16'h0}) begin
            failures++;
            $display("FAIL reset_mid: flags=%b addr=%h w_data=%h words=%0d required 0 %h 0 0",
                     {rx_ready, wr_en, cpu_hold, busy, done, error}, addr, w_data, words_loaded, BASE);
        end
        do_reset();
    endtask

    task automatic test_random_frames();
        logic [7:0] x;
        int n;
        bit same;
        for (int f = 0; f < 6; f++) begin
            n = int'($urandom_range(1, 6));
            pulse_start();
            acc_q.delete();
            make_frame(n, x);
`ifdef MEM_LOADER_CHECKSUM_EN
            frame_q.push_back(x);
`endif
            // Odd frames keep rx_valid high continuously.
            send_frame(((f % 2) != 0) ? 0 : 3, f == 2);
            wait_end();
            checks++;
            if ({done, error, words_loaded, addr} !== {1'b1, 1'b0, 16'(n), BASE + 32'(4 * n)}) begin
                failures++;
                $display("FAIL frame%0d_status: done=%b error=%b words=%0d addr=%h required 1 0 %0d %h",
                         f, done, error, words_loaded, addr, n, BASE + 32'(4 * n));
            end
            same = (acc_q.size() == frame_q.size());
            for (int i = 0; same && (i < frame_q.size()); i++) same = (acc_q[i] === frame_q[i]);
            checks++;
            if (!same || exp_addr_q.size() !== 0) begin
                failures++;
                $display("FAIL frame%0d_bytes: accepted=%0d pending_writes=%0d required %0d 0",
                         f, acc_q.size(), exp_addr_q.size(), frame_q.size());
            end
        end
    endtask

`ifdef MEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] x;
        int wc0;
        x = 8'h00;
        for (int pass = 0; pass < 2; pass++) begin
            wc0 = wr_count;
            pulse_start();
            frame_q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
            x = 8'h00;
            for (int i = 2; i < frame_q.size(); i++) x = x ^ frame_q[i];
            frame_q.push_back((pass == 0) ? x : 8'h00);
            exp_addr_q.push_back(32'h0040_0000); exp_data_q.push_back(32'h1234_5678);
            exp_addr_q.push_back(32'h0040_0004); exp_data_q.push_back(32'hDEAD_BEEF);
            send_frame(1, 1'b0);
            wait_end();
            checks++;
            if ({done, error} !== ((pass == 0) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL csum_pass%0d: done,error=%b required %b", pass, {done, error},
                         (pass == 0) ? 2'b10 : 2'b01);
            end
            checks++;
            if ((wr_count - wc0) !== 2 || words_loaded !== 16'd2) begin
                failures++;
                $display("FAIL csum_writes%0d: writes=%0d words=%0d required 2 2", pass, wr_count - wc0, words_loaded);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_too_long();
        test_timeout();
        test_reset_mid();
        test_random_frames();
`ifdef MEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
